// File: rtl/audio_mixer_if.sv
// audio_mixer_if: bundles the mixer's strobe, channel inputs and mixed-sample
// outputs so that the mixer and whatever feeds it share one typed connection.
//   master : drives sample_stb, ch_bit, ch_vol, ch_en, pokey_in, pokey_en;
//            observes audio_out, audio_valid, busy, overrun
//   slave  : the mixer itself (the opposite directions)
interface audio_mixer_if #(
    parameter int NUM_CH = 2,
    parameter int VOL_W  = 4,
    parameter int OUT_W  = 16
);
    logic                       sample_stb;
    logic [NUM_CH-1:0]          ch_bit;
    logic [NUM_CH*VOL_W-1:0]    ch_vol;
    logic [NUM_CH-1:0]          ch_en;
    logic [3:0]                 pokey_in;
    logic                       pokey_en;
    logic [OUT_W-1:0]           audio_out;
    logic                       audio_valid;
    logic                       busy;
    logic                       overrun;

    modport master (
        output sample_stb, ch_bit, ch_vol, ch_en, pokey_in, pokey_en,
        input  audio_out, audio_valid, busy, overrun
    );

    modport slave (
        input  sample_stb, ch_bit, ch_vol, ch_en, pokey_in, pokey_en,
        output audio_out, audio_valid, busy, overrun
    );
endinterface

// File: rtl/audio_mixer.sv
// audio_mixer: serial mixer for NUM_CH 1-bit TIA-style channels plus one 4-bit
// POKEY channel. A sample_stb snapshots all inputs, one term is accumulated per
// cycle, and the saturated sum is published on audio_out with a one-cycle
// audio_valid pulse.
//   sysclk : clock, all state on rising edge
//   reset  : synchronous, active-high
//   mix    : audio_mixer_if.slave (strobe, channel inputs, mixed output, status)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for sample_stb; snapshot taken on the accepting edge
// S_ACCUM | adding one term per cycle: channels 0..NUM_CH-1, then POKEY
// S_DONE  | final sum ready; saturated result loaded on the leaving edge
module audio_mixer #(
    parameter int NUM_CH     = 2,
    parameter int VOL_W      = 4,
    parameter int OUT_W      = 16,
    parameter int STEP       = 1023,
    parameter int POKEY_STEP = 512
) (
    input logic          sysclk,
    input logic          reset,
    audio_mixer_if.slave mix
);
    // Largest possible |sum|, plus a sign bit; never narrower than OUT_W+4.
    localparam int MAG_MAX = NUM_CH * ((2 ** VOL_W) - 1) * STEP + 8 * POKEY_STEP;
    localparam int MAG_W   = $clog2(MAG_MAX + 1) + 1;
    localparam int ACC_W   = (MAG_W > OUT_W + 4) ? MAG_W : OUT_W + 4;
    localparam int IDX_W   = $clog2(NUM_CH + 1);

    localparam logic [IDX_W-1:0]        IDX_POKEY    = IDX_W'(NUM_CH);
    localparam logic signed [ACC_W-1:0] STEP_S       = ACC_W'(STEP);
    localparam logic signed [ACC_W-1:0] POKEY_STEP_S = ACC_W'(POKEY_STEP);
    localparam logic signed [ACC_W-1:0] POKEY_MID    = ACC_W'(8);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t state, state_nxt;

    logic                     busy;
    logic                     snap_load;
    logic                     acc_en;
    logic                     out_load;

    logic [NUM_CH-1:0]        snap_bit;
    logic [NUM_CH*VOL_W-1:0]  snap_vol;
    logic [NUM_CH-1:0]        snap_en;
    logic [3:0]               snap_pokey;
    logic                     snap_pokey_en;

    logic signed [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  ch_mag;
    logic signed [ACC_W-1:0]  term;
    logic [OUT_W-1:0]         sat_val;

    // State register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mix.sample_stb) state_nxt = S_ACCUM;
            S_ACCUM: if (idx == IDX_POKEY) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy      = 1'b0;
        snap_load = 1'b0;
        acc_en    = 1'b0;
        out_load  = 1'b0;
        case (state)
            S_IDLE:  snap_load = mix.sample_stb;
            S_ACCUM: begin
                busy   = 1'b1;
                acc_en = 1'b1;
            end
            S_DONE: begin
                busy     = 1'b1;
                out_load = 1'b1;
            end
            default: ;
        endcase
    end

    assign mix.busy = busy;

    // Term for the current index, taken from the snapshot only.
    always_comb begin
        ch_mag = '0;
        term   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                ch_mag = signed'(ACC_W'(snap_vol[i*VOL_W +: VOL_W])) * STEP_S;
                if (snap_en[i]) begin
                    term = snap_bit[i] ? ch_mag : -ch_mag;
                end
            end
        end
        if (idx == IDX_POKEY && snap_pokey_en) begin
            term = (signed'(ACC_W'(snap_pokey)) - POKEY_MID) * POKEY_STEP_S;
        end
    end

    always_comb begin
        if (acc > OUT_MAX) begin
            sat_val = OUT_MAX[OUT_W-1:0];
        end else if (acc < OUT_MIN) begin
            sat_val = OUT_MIN[OUT_W-1:0];
        end else begin
            sat_val = acc[OUT_W-1:0];
        end
    end

    // Datapath
    always_ff @(posedge sysclk) begin
        if (reset) begin
            snap_bit        <= '0;
            snap_vol        <= '0;
            snap_en         <= '0;
            snap_pokey      <= '0;
            snap_pokey_en   <= 1'b0;
            acc             <= '0;
            idx             <= '0;
            mix.audio_out   <= '0;
            mix.audio_valid <= 1'b0;
            mix.overrun     <= 1'b0;
        end else begin
            mix.audio_valid <= 1'b0;
            // Strobes arriving in ACCUM or DONE are dropped but flagged.
            mix.overrun     <= mix.sample_stb & busy;
            if (snap_load) begin
                snap_bit      <= mix.ch_bit;
                snap_vol      <= mix.ch_vol;
                snap_en       <= mix.ch_en;
                snap_pokey    <= mix.pokey_in;
                snap_pokey_en <= mix.pokey_en;
                acc           <= '0;
                idx           <= '0;
            end
            if (acc_en) begin
                acc <= acc + term;
                if (idx != IDX_POKEY) begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (out_load) begin
                mix.audio_out   <= sat_val;
                mix.audio_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer: three instances (NUM_CH = 1, 2, 4) share one set of
// stimulus variables; each has its own strobe. Results are compared against a
// plain-arithmetic model of the mix with saturation.
module tb_audio_mixer;
    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [2:0]  stb    = '0;
    logic [7:0]  bits   = '0;
    logic [31:0] vols   = '0;
    logic [7:0]  en     = '0;
    logic [3:0]  pk     = '0;
    logic        pken   = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    always #5 sysclk = ~sysclk;

    audio_mixer_if #(.NUM_CH(1), .VOL_W(4), .OUT_W(16)) if1 ();
    audio_mixer_if #(.NUM_CH(2), .VOL_W(4), .OUT_W(16)) if2 ();
    audio_mixer_if #(.NUM_CH(4), .VOL_W(4), .OUT_W(16)) if4 ();

    assign if1.sample_stb = stb[0];
    assign if1.ch_bit     = bits[0:0];
    assign if1.ch_vol     = vols[3:0];
    assign if1.ch_en      = en[0:0];
    assign if1.pokey_in   = pk;
    assign if1.pokey_en   = pken;

    assign if2.sample_stb = stb[1];
    assign if2.ch_bit     = bits[1:0];
    assign if2.ch_vol     = vols[7:0];
    assign if2.ch_en      = en[1:0];
    assign if2.pokey_in   = pk;
    assign if2.pokey_en   = pken;

    assign if4.sample_stb = stb[2];
    assign if4.ch_bit     = bits[3:0];
    assign if4.ch_vol     = vols[15:0];
    assign if4.ch_en      = en[3:0];
    assign if4.pokey_in   = pk;
    assign if4.pokey_en   = pken;

    audio_mixer #(.NUM_CH(1)) dut1 (.sysclk(sysclk), .reset(reset), .mix(if1));
    audio_mixer #(.NUM_CH(2)) dut2 (.sysclk(sysclk), .reset(reset), .mix(if2));
    audio_mixer #(.NUM_CH(4)) dut4 (.sysclk(sysclk), .reset(reset), .mix(if4));

    logic [15:0] aout [3];
    logic        vld  [3];
    logic        bsy  [3];
    logic        ovr  [3];

    assign aout[0] = if1.audio_out;   assign vld[0] = if1.audio_valid;
    assign aout[1] = if2.audio_out;   assign vld[1] = if2.audio_valid;
    assign aout[2] = if4.audio_out;   assign vld[2] = if4.audio_valid;
    assign bsy[0]  = if1.busy;        assign ovr[0] = if1.overrun;
    assign bsy[1]  = if2.busy;        assign ovr[1] = if2.overrun;
    assign bsy[2]  = if4.busy;        assign ovr[2] = if4.overrun;

    function automatic int nch_of(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
    endfunction

    // Sum of +/-vol*1023 per enabled channel, plus (pokey-8)*512, clamped to 16 bits.
    function automatic int mix_model(input int nch, input logic [7:0] b,
                                     input logic [31:0] v, input logic [7:0] e,
                                     input logic [3:0] p, input logic pe);
        int s;
        int m;
        s = 0;
        for (int i = 0; i < nch; i++) begin
            if (e[i]) begin
                m = int'(v[i*4 +: 4]) * 1023;
                s += b[i] ? m : -m;
            end
        end
        if (pe) s += (int'(p) - 8) * 512;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic run_mix(input int sel, input logic [7:0] b, input logic [31:0] v,
                           input logic [7:0] e, input logic [3:0] p, input logic pe,
                           input bit scramble, input string name);
        int          lat;
        int          nv;
        int          nch;
        logic [15:0] got;
        logic [15:0] exp16;
        nch   = nch_of(sel);
        exp16 = 16'(mix_model(nch, b, v, e, p, pe));
        bits = b; vols = v; en = e; pk = p; pken = pe;
        stb[sel] = 1'b1;
        @(negedge sysclk);
        stb[sel] = 1'b0;
        lat = -1; nv = 0; got = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge sysclk);
            if (vld[sel]) begin
                nv++;
                if (lat < 0) begin
                    lat = k;
                    got = aout[sel];
                end
            end
            if (scramble && k <= 2) begin
                bits = 8'($urandom); vols = $urandom; en = 8'($urandom);
                pk = 4'($urandom); pken = 1'($urandom);
            end
        end
        vectors++;
        if (lat !== nch + 2) begin
            miscompares++;
            $display("FAIL %s latency: got %0d, expected %0d", name, lat, nch + 2);
        end
        vectors++;
        if (nv !== 1) begin
            miscompares++;
            $display("FAIL %s valid_count: got %0d, expected 1", name, nv);
        end
        vectors++;
        if (got !== exp16) begin
            miscompares++;
            $display("FAIL %s audio_out: got %h, expected %h", name, got, exp16);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        for (int s = 0; s < 3; s++) begin
            vectors++;
            if (aout[s] !== 16'h0 || vld[s] !== 1'b0 || bsy[s] !== 1'b0 || ovr[s] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got out=%h valid=%b busy=%b ovr=%b, expected 0/0/0/0",
                         s, aout[s], vld[s], bsy[s], ovr[s]);
            end
        end
        reset = 1'b0;
        @(negedge sysclk);
        vectors++;
        if (bsy[1] !== 1'b0 || aout[1] !== 16'h0) begin
            miscompares++;
            $display("FAIL post_reset: got busy=%b out=%h, expected 0/0000", bsy[1], aout[1]);
        end
    endtask

    task automatic test_directed();
        run_mix(1, 8'h03, 32'hFF, 8'h03, 4'h0, 1'b0, 1'b0, "sum_defaults");
        run_mix(1, 8'h01, 32'h38, 8'h03, 4'd12, 1'b1, 1'b0, "mixed_signs");
        run_mix(0, 8'h01, 32'h7, 8'h01, 4'd3, 1'b1, 1'b0, "single_channel");
    endtask

    task automatic test_saturation();
        run_mix(2, 8'h0F, 32'hFFFF, 8'h0F, 4'h8, 1'b0, 1'b0, "sat_high");
        run_mix(2, 8'h00, 32'hFFFF, 8'h0F, 4'h0, 1'b1, 1'b0, "sat_low");
    endtask

    task automatic test_snapshot();
        run_mix(1, 8'h02, 32'hF1, 8'h01, 4'h5, 1'b0, 1'b1, "enable_snapshot");
    endtask

    // stb_k = 1 lands in ACCUM, stb_k = 3 lands in DONE.
    task automatic test_overrun(input int stb_k);
        int          nv;
        int          no;
        int          ovr_k;
        logic [15:0] got;
        bits = 8'h01; vols = 32'h35; en = 8'h03; pk = 4'h0; pken = 1'b0;
        stb[1] = 1'b1;
        @(negedge sysclk);
        stb[1] = 1'b0;
        nv = 0; no = 0; ovr_k = -1; got = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge sysclk);
            if (vld[1]) begin
                if (nv == 0) got = aout[1];
                nv++;
            end
            if (ovr[1]) begin
                if (no == 0) ovr_k = k;
                no++;
            end
            stb[1] = (k == stb_k);
            if (k == stb_k) begin
                bits = 8'h02; vols = 32'hFF; en = 8'h03; pk = 4'hF; pken = 1'b1;
            end
        end
        vectors++;
        if (nv !== 1) begin
            miscompares++;
            $display("FAIL overrun_valid_count[%0d]: got %0d, expected 1", stb_k, nv);
        end
        vectors++;
        if (got !== 16'd2046) begin
            miscompares++;
            $display("FAIL overrun_result[%0d]: got %h, expected %h", stb_k, got, 16'd2046);
        end
        vectors++;
        if (no !== 1 || ovr_k !== stb_k + 1) begin
            miscompares++;
            $display("FAIL overrun_pulse[%0d]: got count=%0d at=%0d, expected count=1 at=%0d",
                     stb_k, no, ovr_k, stb_k + 1);
        end
    endtask

    task automatic test_reset_mid();
        int nv;
        run_mix(1, 8'h03, 32'hFF, 8'h03, 4'h0, 1'b0, 1'b0, "pre_abort");
        bits = 8'h01; vols = 32'h22; en = 8'h03; pk = 4'h9; pken = 1'b1;
        stb[1] = 1'b1;
        @(negedge sysclk);
        stb[1] = 1'b0;
        nv = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge sysclk);
            if (vld[1]) nv++;
            if (k == 1) begin
                vectors++;
                if (bsy[1] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL abort_busy_before: got %b, expected 1", bsy[1]);
                end
                reset = 1'b1;
            end
            if (k == 2) begin
                vectors++;
                if (bsy[1] !== 1'b0 || aout[1] !== 16'h0) begin
                    miscompares++;
                    $display("FAIL abort_state: got busy=%b out=%h, expected 0/0000", bsy[1], aout[1]);
                end
                reset = 1'b0;
            end
        end
        vectors++;
        if (nv !== 0) begin
            miscompares++;
            $display("FAIL abort_valid_count: got %0d, expected 0", nv);
        end
        run_mix(1, 8'h02, 32'h9A, 8'h03, 4'h1, 1'b1, 1'b0, "after_abort");
    endtask

    task automatic test_stb_with_reset();
        int nv;
        bits = 8'h03; vols = 32'hFF; en = 8'h03;
        reset = 1'b1; stb[1] = 1'b1;
        @(negedge sysclk);
        reset = 1'b0; stb[1] = 1'b0;
        nv = 0;
        vectors++;
        if (bsy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL stb_in_reset_busy: got %b, expected 0", bsy[1]);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge sysclk);
            if (vld[1]) nv++;
        end
        vectors++;
        if (nv !== 0) begin
            miscompares++;
            $display("FAIL stb_in_reset_valid: got %0d, expected 0", nv);
        end
    endtask

    task automatic test_back_to_back();
        int          k1;
        int          k2;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [15:0] e1;
        logic [15:0] e2;
        e1 = 16'(mix_model(2, 8'h01, 32'h4A, 8'h03, 4'h2, 1'b1));
        e2 = 16'(mix_model(2, 8'h02, 32'hC1, 8'h03, 4'hE, 1'b1));
        bits = 8'h01; vols = 32'h4A; en = 8'h03; pk = 4'h2; pken = 1'b1;
        stb[1] = 1'b1;
        @(negedge sysclk);
        stb[1] = 1'b0;
        k1 = -1; k2 = -1; v1 = '0; v2 = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge sysclk);
            stb[1] = 1'b0;
            if (vld[1]) begin
                if (k1 < 0) begin
                    k1 = k; v1 = aout[1];
                    bits = 8'h02; vols = 32'hC1; en = 8'h03; pk = 4'hE; pken = 1'b1;
                    stb[1] = 1'b1;
                end else if (k2 < 0) begin
                    k2 = k; v2 = aout[1];
                end
            end
        end
        vectors++;
        if (k1 !== 4 || v1 !== e1) begin
            miscompares++;
            $display("FAIL b2b_first: got at=%0d out=%h, expected at=4 out=%h", k1, v1, e1);
        end
        vectors++;
        if (k2 !== 9 || v2 !== e2) begin
            miscompares++;
            $display("FAIL b2b_second: got at=%0d out=%h, expected at=9 out=%h", k2, v2, e2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 36; n++) begin
            run_mix(n % 3, 8'($urandom), $urandom, 8'($urandom),
                    4'($urandom_range(0, 15)), 1'($urandom), (n % 4) == 3, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_snapshot();
        test_overrun(1);
        test_overrun(3);
        test_reset_mid();
        test_stb_with_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 Parameter NUM_CH, default 2, number of TIA-style 1-bit audio channels; legal range 1..8.
REQ-002 Parameter VOL_W, default 4, width of each channel volume field.
REQ-003 Parameter OUT_W, default 16, width of the signed mixed output.
REQ-004 Parameter STEP, default 1023, per-volume-unit magnitude of a 1-bit channel.
REQ-005 Parameter POKEY_STEP, default 512, per-unit magnitude of the 4-bit POKEY channel.
REQ-006 sysclk  in  1  the single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 sample_stb  in  1  one-cycle request to start one mix.
REQ-009 ch_bit  in  NUM_CH  current output bit of each channel.
REQ-010 ch_vol  in  NUM_CH*VOL_W  unsigned volume per channel; channel i uses bits [i*VOL_W +: VOL_W].
REQ-011 ch_en  in  NUM_CH  per-channel enable; a disabled channel contributes 0.
REQ-012 pokey_in  in  4  unsigned POKEY sample.
REQ-013 pokey_en  in  1  POKEY channel enable.
REQ-014 audio_out  out  OUT_W  signed two's-complement mixed sample, held between updates.
REQ-015 audio_valid  out  1  one-cycle pulse when audio_out has just been updated.
REQ-016 busy  out  1  high while a mix is in progress.
REQ-017 overrun  out  1  one-cycle pulse when sample_stb arrives while busy.

Function
REQ-018 Three states: IDLE, ACCUM, DONE.
REQ-019 IDLE with sample_stb=1:
- snapshot ch_bit, ch_vol, ch_en, pokey_in and pokey_en into registers;
- clear the accumulator;
- clear the channel index;
- go to ACCUM.
REQ-020 ACCUM adds one term per cycle over index 0..NUM_CH-1, then adds the POKEY term at index NUM_CH; after the POKEY term it goes to DONE.
REQ-021 Channel term = +vol*STEP if bit=1, -vol*STEP if bit=0, 0 if disabled; all terms are computed from the snapshot only.
REQ-022 POKEY term = (pokey_in-8)*POKEY_STEP if pokey_en=1, else 0.
REQ-023 The accumulator is signed and wide enough that no intermediate sum can overflow (at least OUT_W+4 bits).
REQ-024 DONE:
- load audio_out with the accumulator saturated to the signed OUT_W range: above max gives max, below min gives min;
- assert audio_valid for that one cycle;
- return to IDLE.
REQ-025 Latency: audio_valid is high in the cycle that begins NUM_CH+2 rising edges after the edge that sampled sample_stb; audio_out changes on that same edge.
REQ-026 busy = 1 in ACCUM and DONE, 0 in IDLE.
REQ-027 sample_stb while busy=1, including in DONE:
- is ignored: no snapshot and no restart;
- pulses overrun for one cycle, on the next edge.
REQ-028 Input changes during ACCUM have no effect on the sample in progress.
REQ-029 Back-to-back mixes: a sample_stb in the first IDLE cycle after DONE is accepted.
REQ-030 NUM_CH=1 is legal: ACCUM lasts 2 cycles.

Reset
REQ-031 On reset: state=IDLE, audio_out=0, audio_valid=0, busy=0, overrun=0, accumulator=0, index=0.
REQ-032 Reset asserted mid-ACCUM aborts the mix; no audio_valid is produced for it, and audio_out reads 0 on the cycle after reset.
REQ-033 sample_stb coincident with reset is ignored.

Verification
REQ-034 Sum, defaults: ch_bit=2'b11, vol=15,15, ch_en=2'b11, pokey_en=0, strobe -> after 4 edges audio_valid=1, audio_out=0x77E2 (30690).
REQ-035 Mixed signs: ch0 bit1 vol8, ch1 bit0 vol3, pokey_en=1, pokey_in=12 -> audio_out = 8184-3069+2048 = 0x1BFB (7163).
REQ-036 Saturation, NUM_CH=4: all bit1 vol15 -> 0x7FFF; all bit0 vol15 with pokey_in=0 enabled -> 0x8000.
REQ-037 Enable mask and snapshot: ch_en=2'b01 with ch1 bit1 vol15, ch0 bit0 vol1, strobe, then change all inputs during ACCUM -> audio_out=0xFC01 (-1023).
REQ-038 Overrun: strobe, strobe again 2 cycles later -> single audio_valid, overrun pulse one cycle, result from the first snapshot only.
REQ-039 Reset mid-ACCUM -> no audio_valid, audio_out=0, busy=0; the next strobe completes normally.
